// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit for the execute stage.
// Owns the HI and LO registers, runs MULT/MULTU/DIV/DIVU one bit per cycle
// while stalling the pipeline, and performs single-cycle MTHI/MTLO writes.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             validE,
  input  logic [2:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             cancelE,
  output logic             stallE,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   acc_reg;       // partial product high word / partial remainder
  logic [WIDTH-1:0]   mq_reg;        // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0]   mcand_reg;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   dividend_reg;  // dividend as given, for the divide-by-zero HI result
  logic               is_div_reg;
  logic               neg_res_reg;   // operand signs differ
  logic               neg_rem_reg;   // signed dividend was negative
  logic               div_zero_reg;

  logic               is_arith;
  logic               is_signed;
  logic               accept;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;

  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   hi_fix, lo_fix;

  // Request decode and operand magnitude preparation
  always_comb begin
    is_arith  = (opE >= OP_MULT) && (opE <= OP_DIVU);
    is_signed = (opE == OP_MULT) || (opE == OP_DIV);
    accept    = (state_reg == IDLE) && validE && !cancelE && is_arith;
    a_neg     = is_signed && srcaE[WIDTH-1];
    b_neg     = is_signed && srcbE[WIDTH-1];
    mag_a     = a_neg ? -srcaE : srcaE;
    mag_b     = b_neg ? -srcbE : srcbE;
  end

  // One iteration step: shift-add multiply or restoring shift-subtract divide
  always_comb begin
    mul_sum   = {1'b0, acc_reg} + {1'b0, mcand_reg & {WIDTH{mq_reg[0]}}};
    div_shift = {acc_reg, mq_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand_reg};
    div_ge    = !div_diff[WIDTH];
  end

  // Final sign fixups applied while in DONE
  always_comb begin
    prod_mag = {acc_reg, mq_reg};
    prod_fix = neg_res_reg ? -prod_mag : prod_mag;
    quo_fix  = neg_res_reg ? -mq_reg : mq_reg;
    rem_fix  = neg_rem_reg ? -acc_reg : acc_reg;
    hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
    lo_fix   = prod_fix[WIDTH-1:0];
    if (is_div_reg) begin
      if (div_zero_reg) begin
        hi_fix = dividend_reg;
        lo_fix = {WIDTH{1'b1}};
      end else begin
        hi_fix = rem_fix;
        lo_fix = quo_fix;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and stall generation
  always_comb begin
    state_next = state_reg;
    stallE     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          stallE     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cancelE) begin
          state_next = IDLE;
        end else begin
          stallE = 1'b1;
          if (cnt_reg == LAST_ITER) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, HI/LO writes
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg       <= '0;
      lo_reg       <= '0;
      cnt_reg      <= '0;
      acc_reg      <= '0;
      mq_reg       <= '0;
      mcand_reg    <= '0;
      dividend_reg <= '0;
      is_div_reg   <= 1'b0;
      neg_res_reg  <= 1'b0;
      neg_rem_reg  <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            is_div_reg   <= (opE == OP_DIV) || (opE == OP_DIVU);
            neg_res_reg  <= a_neg ^ b_neg;
            neg_rem_reg  <= a_neg;
            div_zero_reg <= (srcbE == '0);
            dividend_reg <= srcaE;
            cnt_reg      <= '0;
            acc_reg      <= '0;
            if ((opE == OP_DIV) || (opE == OP_DIVU)) begin
              mq_reg    <= mag_a;
              mcand_reg <= mag_b;
            end else begin
              mq_reg    <= mag_b;
              mcand_reg <= mag_a;
            end
          end else if (validE && !cancelE && (opE == OP_MTHI)) begin
            hi_reg <= srcaE;
          end else if (validE && !cancelE && (opE == OP_MTLO)) begin
            lo_reg <= srcaE;
          end
        end
        BUSY: begin
          if (!cancelE) begin
            cnt_reg <= cnt_reg + CNT_ONE;
            if (is_div_reg) begin
              acc_reg <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
              mq_reg  <= {mq_reg[WIDTH-2:0], div_ge};
            end else begin
              acc_reg <= mul_sum[WIDTH:1];
              mq_reg  <= {mul_sum[0], mq_reg[WIDTH-1:1]};
            end
          end
        end
        DONE: begin
          if (!cancelE) begin
            hi_reg <= hi_fix;
            lo_reg <= lo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_o   = hi_reg;
  assign lo_o   = lo_reg;
  assign busy_o = (state_reg == BUSY);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed testbench for hilo_muldiv_unit: vector table plus hand sequences
// for cancel, mid-operation reset and held-request corner cases.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        validE;
  logic [2:0]  opE;
  logic [31:0] srcaE, srcbE;
  logic        cancelE;
  logic        stallE;
  logic [31:0] hi_o, lo_o;
  logic        busy_o;

  int tests = 0;
  int fails = 0;

  hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .validE(validE), .opE(opE),
    .srcaE(srcaE), .srcbE(srcbE), .cancelE(cancelE),
    .stallE(stallE), .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stall;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one request, hold it through the whole stall including DONE,
  // then drop it; returns the number of stalled cycles observed.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int stall_cnt);
    @(negedge clk);
    validE = 1'b1; opE = op; srcaE = a; srcbE = b;
    #1;
    stall_cnt = 0;
    while (stallE && stall_cnt < 100) begin
      stall_cnt++;
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    validE = 1'b0; opE = 3'd0; srcaE = '0; srcbE = '0;
    #1;
  endtask

  int sc;
  int iter;

  initial begin
    rst = 1'b1; validE = 1'b0; opE = 3'd0; srcaE = '0; srcbE = '0; cancelE = 1'b0;

    vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 33};
    vecs[1]  = '{3'd2, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 33};
    vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[3]  = '{3'd4, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 33};
    vecs[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[5]  = '{3'd4, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 33};
    vecs[6]  = '{3'd3, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 33};
    vecs[7]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
    vecs[8]  = '{3'd1, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 33};
    vecs[9]  = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
    vecs[10] = '{3'd5, 32'hAAAA5555, 32'h00000000, 32'hAAAA5555, 32'hFFFFFFFD, 0};
    vecs[11] = '{3'd7, 32'h11111111, 32'h22222222, 32'hAAAA5555, 32'hFFFFFFFD, 0};
    vecs[12] = '{3'd6, 32'h0BADF00D, 32'h00000000, 32'hAAAA5555, 32'h0BADF00D, 0};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset hi", hi_o, 32'h0);
    chk("reset lo", lo_o, 32'h0);
    chk("reset stall", {31'b0, stallE}, 32'h0);
    chk("reset busy", {31'b0, busy_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back MTHI / MTLO, no stall
    @(negedge clk);
    validE = 1'b1; opE = 3'd5; srcaE = 32'h12345678; #1;
    chk("mthi stall", {31'b0, stallE}, 32'h0);
    @(negedge clk);
    opE = 3'd6; srcaE = 32'h9ABCDEF0; #1;
    chk("mtlo stall", {31'b0, stallE}, 32'h0);
    @(negedge clk);
    validE = 1'b0; opE = 3'd0; srcaE = '0; #1;
    chk("mt hi", hi_o, 32'h12345678);
    chk("mt lo", lo_o, 32'h9ABCDEF0);

    // Table-driven vectors
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, sc);
      $display("[TB] vec %0d op=%0d a=%08h b=%08h -> hi=%08h lo=%08h stall=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, hi_o, lo_o, sc);
      chk($sformatf("vec%0d stall", i), 32'(sc), 32'(vecs[i].stall));
      chk($sformatf("vec%0d hi", i), hi_o, vecs[i].hi);
      chk($sformatf("vec%0d lo", i), lo_o, vecs[i].lo);
      chk($sformatf("vec%0d busy", i), {31'b0, busy_o}, 32'h0);
    end

    // Cancel at iteration 10: HI/LO keep AAAA5555 / 0BADF00D
    @(negedge clk);
    validE = 1'b1; opE = 3'd4; srcaE = 32'd100; srcbE = 32'd7;
    @(negedge clk);
    validE = 1'b0; opE = 3'd0;
    for (iter = 0; iter < 10; iter++) @(negedge clk);
    cancelE = 1'b1; #1;
    chk("cancel stall drop", {31'b0, stallE}, 32'h0);
    @(negedge clk);
    cancelE = 1'b0; #1;
    chk("cancel busy", {31'b0, busy_o}, 32'h0);
    chk("cancel stall", {31'b0, stallE}, 32'h0);
    repeat (40) @(negedge clk);
    #1;
    $display("[TB] cancel seq -> hi=%08h lo=%08h", hi_o, lo_o);
    chk("cancel hi", hi_o, 32'hAAAA5555);
    chk("cancel lo", lo_o, 32'h0BADF00D);

    // Reset at iteration 20
    @(negedge clk);
    validE = 1'b1; opE = 3'd4; srcaE = 32'd100; srcbE = 32'd7;
    @(negedge clk);
    validE = 1'b0; opE = 3'd0;
    for (iter = 0; iter < 20; iter++) @(negedge clk);
    #1;
    chk("pre-rst busy", {31'b0, busy_o}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; #1;
    $display("[TB] reset seq -> hi=%08h lo=%08h busy=%0b", hi_o, lo_o, busy_o);
    chk("rst hi", hi_o, 32'h0);
    chk("rst lo", lo_o, 32'h0);
    chk("rst busy", {31'b0, busy_o}, 32'h0);
    chk("rst stall", {31'b0, stallE}, 32'h0);

    // MULTU held through DONE, then a new MULTU the very next cycle
    @(negedge clk);
    validE = 1'b1; opE = 3'd2; srcaE = 32'd3; srcbE = 32'd5; #1;
    sc = 0;
    while (stallE && sc < 100) begin
      sc++;
      @(negedge clk);
      #1;
    end
    chk("held1 stall", 32'(sc), 32'd33);
    chk("held1 done busy", {31'b0, busy_o}, 32'h0);
    @(negedge clk);
    srcaE = 32'd6; srcbE = 32'd7; #1;
    chk("held1 hi", hi_o, 32'h0);
    chk("held1 lo", lo_o, 32'd15);
    chk("held2 no rebusy", {31'b0, busy_o}, 32'h0);
    chk("held2 accept", {31'b0, stallE}, 32'h1);
    sc = 0;
    while (stallE && sc < 100) begin
      sc++;
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    validE = 1'b0; opE = 3'd0; #1;
    $display("[TB] held seq -> hi=%08h lo=%08h stall=%0d", hi_o, lo_o, sc);
    chk("held2 stall", 32'(sc), 32'd33);
    chk("held2 hi", hi_o, 32'h0);
    chk("held2 lo", lo_o, 32'd42);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
